// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the memory port arbiter
package riscv_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} arb_gnt_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker, the requester that was not granted last wins a tie
module rr_pick2
  import riscv_pkg::*;
(
  input  logic     req_i,
  input  logic     req_d,
  input  arb_gnt_t last,
  output arb_gnt_t gnt,
  output logic     valid
);
  // winner selection
  always_comb begin
    valid = req_i | req_d;
    gnt = (req_i & req_d) ? (last == GNT_I ? GNT_D : GNT_I) : (req_i ? GNT_I : GNT_D);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction in flight
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                err,
  output logic                m_req,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W/8-1:0] m_we,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_ready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);
  localparam int BE_W = DATA_W / 8;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  arb_state_t state_q, state_d;
  arb_gnt_t gnt_q, gnt_d, pick;
  logic pick_v, grant, finish, timeout_hit;
  logic [CW-1:0] cnt_q, cnt_d;
  logic m_req_q, m_req_d, i_ack_q, i_ack_d, d_ack_q, d_ack_d, err_q, err_d, busy_q, busy_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [BE_W-1:0] m_we_q, m_we_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d, resp;

  rr_pick2 u_pick (
    .req_i (i_req),
    .req_d (d_req),
    .last  (gnt_q),
    .gnt   (pick),
    .valid (pick_v)
  );

  assign grant = state_q == ARB_IDLE && pick_v;
  assign timeout_hit = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1) && !m_rvalid;
  assign finish = state_d == ARB_DONE;
  assign resp = m_rvalid ? m_rdata : '0;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ARB_IDLE;
    else state_q <= state_d;
  end

  // next state: completion is either a response or an expired WAIT counter
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  state_d = pick_v ? ARB_ISSUE : ARB_IDLE;
      ARB_ISSUE: state_d = !m_ready ? ARB_ISSUE : (m_rvalid ? ARB_DONE : ARB_WAIT);
      ARB_WAIT:  state_d = (m_rvalid || timeout_hit) ? ARB_DONE : ARB_WAIT;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // next values of the registered outputs; the winner register doubles as last grant
  always_comb begin
    gnt_d = grant ? pick : gnt_q;
    m_addr_d = grant ? (pick == GNT_I ? i_addr : d_addr) : m_addr_q;
    m_we_d = grant ? (pick == GNT_I ? '0 : d_we) : m_we_q;
    m_wdata_d = grant ? (pick == GNT_I ? '0 : d_wdata) : m_wdata_q;
    m_req_d = state_d == ARB_ISSUE;
    busy_d = state_d != ARB_IDLE;
    cnt_d = state_q == ARB_WAIT ? cnt_q + 1'b1 : '0;
    i_ack_d = finish && gnt_q == GNT_I;
    d_ack_d = finish && gnt_q == GNT_D;
    err_d = finish && !m_rvalid;
    i_rdata_d = i_ack_d ? resp : '0;
    d_rdata_d = d_ack_d ? resp : '0;
  end

  // output, capture and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q <= GNT_D;
      cnt_q <= '0;
      m_req_q <= 1'b0;
      m_addr_q <= '0;
      m_we_q <= '0;
      m_wdata_q <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      err_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q <= 1'b0;
    end else begin
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      m_req_q <= m_req_d;
      m_addr_q <= m_addr_d;
      m_we_q <= m_we_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      err_q <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      busy_q <= busy_d;
    end
  end

  assign m_req = m_req_q;
  assign m_addr = m_addr_q;
  assign m_we = m_we_q;
  assign m_wdata = m_wdata_q;
  assign i_ack = i_ack_q;
  assign d_ack = d_ack_q;
  assign err = err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy = busy_q;
endmodule
